// File: rtl/xuanze_pkg.sv
// Shared constants and helpers for the xuanze channel selector.
// Both the arbiter and its bus interface import this package.
package xuanze_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Channel-index width; a two-channel selector still needs one bit.
   function automatic int sel_width(input int nch);
      return (nch <= 2) ? 1 : $clog2(nch);
   endfunction

endpackage

// File: rtl/xuanze_arb_if.sv
// Producer/consumer bundle for xuanze_arb: per-channel valid/ready inputs,
// one registered output channel, and the runtime mode/select controls.
interface xuanze_arb_if
   import xuanze_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NCH   = 4
);
   localparam int SELW = sel_width(NCH);

   logic                 mode;
   logic [SELW-1:0]      sel;
   logic [NCH-1:0]       in_valid;
   logic [NCH*WIDTH-1:0] in_data;
   logic [NCH-1:0]       in_ready;
   logic                 out_valid;
   logic [WIDTH-1:0]     out_data;
   logic [SELW-1:0]      out_ch;
   logic                 out_ready;

   modport master (
      output mode, sel, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ch
   );

   modport slave (
      input  mode, sel, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ch
   );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority encoder: returns the first asserted request found when
// scanning upward from ptr and wrapping at NCH (not at a power of two).
module rr_pick #(
   parameter int NCH  = 4,
   parameter int SELW = 2
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   output logic            gnt_vld,
   output logic [SELW-1:0] gnt_idx
);

   int idx;

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves
      // it unassigned, which would otherwise infer a latch.
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      // Scan from the farthest offset down so the nearest request wins last.
      for (int k = NCH - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NCH) idx = idx - NCH;
         if (req[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = SELW'(idx);
         end
      end
   end

endmodule

// File: rtl/xuanze_arb.sv
// N-channel registered selector: fixed-select or round-robin grant feeding a
// one-entry output register with full-throughput valid/ready handshake.
module xuanze_arb
   import xuanze_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NCH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   xuanze_arb_if.slave bus
);
   localparam int SELW = sel_width(NCH);

   logic [SELW-1:0] ptr;
   logic [NCH-1:0]  fixed_req;
   logic [NCH-1:0]  pick_req;
   logic [SELW-1:0] pick_ptr;
   logic            gnt_vld;
   logic [SELW-1:0] gnt_idx;
   logic            can_accept;
   logic            take;

   // Fixed mode reuses the encoder with only the selected request visible;
   // a sel beyond NCH-1 matches no channel and therefore never grants.
   always_comb begin
      for (int i = 0; i < NCH; i++)
         fixed_req[i] = bus.in_valid[i] && (bus.sel == SELW'(i));
   end

   assign pick_req = (bus.mode == MODE_RR) ? bus.in_valid : fixed_req;
   assign pick_ptr = (bus.mode == MODE_RR) ? ptr : '0;

   rr_pick #(.NCH(NCH), .SELW(SELW)) u_pick (
      .req     (pick_req),
      .ptr     (pick_ptr),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx)
   );

   assign can_accept = !bus.out_valid || bus.out_ready;
   assign take       = !rst && can_accept && gnt_vld;

   always_comb begin
      for (int i = 0; i < NCH; i++)
         bus.in_ready[i] = take && (gnt_idx == SELW'(i));
   end

   always_ff @(posedge clk) begin
      // NOTE: registered state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_ch    <= '0;
         ptr           <= '0;
      end else if (take) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= bus.in_data[int'(gnt_idx)*WIDTH +: WIDTH];
         bus.out_ch    <= gnt_idx;
         if (bus.mode == MODE_RR)
            ptr <= (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule
